id_stage_pipe: RTL

//  Parametrised RV32I/E decode stage with an integrated ID/EX pipeline register.

---
 rtl/id_stage_pipe_if.sv | 41 ++++
 rtl/id_stage_pipe.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/id_stage_pipe_if.sv
// ID-stage bus: IF/ID-side inputs, WB write port, and registered ID/EX outputs.
interface id_stage_pipe_if #(
  parameter int unsigned XLEN = 32
) ();
  logic            valid_id;
  logic [XLEN-1:0] PC_ID;
  logic [31:0]     INSTRUCTION_ID;
  logic            flush_id;
  logic            hold_ex;
  logic            RegWrite_WB;
  logic [4:0]      RD_WB;
  logic [XLEN-1:0] ALU_DATA_WB;
  logic            stall_id;
  logic            valid_ex;
  logic [XLEN-1:0] PC_EX;
  logic [XLEN-1:0] IMM_EX;
  logic [XLEN-1:0] REG_DATA1_EX;
  logic [XLEN-1:0] REG_DATA2_EX;
  logic [2:0]      FUNCT3_EX;
  logic [6:0]      FUNCT7_EX;
  logic [6:0]      OPCODE_EX;
  logic [4:0]      RD_EX;
  logic [4:0]      RS1_EX;
  logic [4:0]      RS2_EX;

  // Upstream/WB side drives instructions and write-back, observes EX outputs
  modport master (
    output valid_id, PC_ID, INSTRUCTION_ID, flush_id, hold_ex,
           RegWrite_WB, RD_WB, ALU_DATA_WB,
    input  stall_id, valid_ex, PC_EX, IMM_EX, REG_DATA1_EX, REG_DATA2_EX,
           FUNCT3_EX, FUNCT7_EX, OPCODE_EX, RD_EX, RS1_EX, RS2_EX
  );

  // Decode stage side
  modport slave (
    input  valid_id, PC_ID, INSTRUCTION_ID, flush_id, hold_ex,
           RegWrite_WB, RD_WB, ALU_DATA_WB,
    output stall_id, valid_ex, PC_EX, IMM_EX, REG_DATA1_EX, REG_DATA2_EX,
           FUNCT3_EX, FUNCT7_EX, OPCODE_EX, RD_EX, RS1_EX, RS2_EX
  );
endinterface

// File: rtl/id_stage_pipe.sv
// RV32I/E decode stage: register file with WB bypass, immediate generation,
// load-use hazard detection and the ID/EX pipeline register.
module id_stage_pipe #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned NREG      = 32,
  parameter bit          BYPASS_WB = 1'b1
) (
  input logic           clk,
  input logic           reset,
  id_stage_pipe_if.slave bus
);

  localparam int unsigned IDXW = $clog2(NREG);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  logic [XLEN-1:0] rf_q [NREG];
  logic [XLEN-1:0] rf_d [NREG];

  logic [31:0]     instr;
  logic [6:0]      opcode;
  logic [4:0]      rs1, rs2, rd;
  logic [XLEN-1:0] rdata1, rdata2, imm;
  logic            rs1_used, rs2_used, load_use;

  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_q, pc_d, imm_q, imm_d, data1_q, data1_d, data2_q, data2_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [6:0]      funct7_q, funct7_d, opcode_q, opcode_d;
  logic [4:0]      rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;

  assign instr  = bus.INSTRUCTION_ID;
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];

  // Register file write port; x0 and out-of-range indices are never written
  always_comb begin
    rf_d = rf_q;
    if (bus.RegWrite_WB && bus.RD_WB != 5'd0 && 32'(bus.RD_WB) < NREG)
      rf_d[bus.RD_WB[IDXW-1:0]] = bus.ALU_DATA_WB;
  end

  // Register file storage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NREG); i++) rf_q[i] <= '0;
    end else begin
      rf_q <= rf_d;
    end
  end

  // Read ports with optional same-cycle WB bypass
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (rs1 != 5'd0 && 32'(rs1) < NREG) begin
      if (BYPASS_WB && bus.RegWrite_WB && bus.RD_WB == rs1) rdata1 = bus.ALU_DATA_WB;
      else                                                  rdata1 = rf_q[rs1[IDXW-1:0]];
    end
    if (rs2 != 5'd0 && 32'(rs2) < NREG) begin
      if (BYPASS_WB && bus.RegWrite_WB && bus.RD_WB == rs2) rdata2 = bus.ALU_DATA_WB;
      else                                                  rdata2 = rf_q[rs2[IDXW-1:0]];
    end
  end

  // Immediate generation, sign-extended to XLEN
  always_comb begin
    imm = '0;
    case (opcode)
      OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM:
        imm = XLEN'($signed(instr[31:20]));
      OP_STORE:
        imm = XLEN'($signed({instr[31:25], instr[11:7]}));
      OP_BRANCH:
        imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      OP_LUI, OP_AUIPC:
        imm = XLEN'($signed({instr[31:12], 12'b0}));
      OP_JAL:
        imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
      default:
        imm = '0;
    endcase
  end

  // Source-operand usage and load-use hazard against the load sitting in EX
  always_comb begin
    rs1_used = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
    rs2_used = (opcode == OP_REG || opcode == OP_STORE || opcode == OP_BRANCH);
    load_use = valid_q && opcode_q == OP_LOAD && rd_q != 5'd0 && bus.valid_id &&
               ((rs1_used && rs1 == rd_q) || (rs2_used && rs2 == rd_q));
  end

  assign bus.stall_id = bus.hold_ex || (load_use && !bus.flush_id);

  // ID/EX next state: hold > flush > load-use bubble > capture
  always_comb begin
    valid_d  = valid_q;
    pc_d     = pc_q;
    imm_d    = imm_q;
    data1_d  = data1_q;
    data2_d  = data2_q;
    funct3_d = funct3_q;
    funct7_d = funct7_q;
    opcode_d = opcode_q;
    rd_d     = rd_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    if (bus.hold_ex) begin
      valid_d = valid_q;
    end else if (bus.flush_id || load_use) begin
      valid_d = 1'b0;
    end else begin
      valid_d  = bus.valid_id;
      pc_d     = bus.PC_ID;
      imm_d    = imm;
      data1_d  = rdata1;
      data2_d  = rdata2;
      funct3_d = instr[14:12];
      funct7_d = instr[31:25];
      opcode_d = opcode;
      rd_d     = rd;
      rs1_d    = rs1;
      rs2_d    = rs2;
    end
  end

  // ID/EX pipeline register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q  <= 1'b0;
      pc_q     <= '0;
      imm_q    <= '0;
      data1_q  <= '0;
      data2_q  <= '0;
      funct3_q <= '0;
      funct7_q <= '0;
      opcode_q <= '0;
      rd_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      pc_q     <= pc_d;
      imm_q    <= imm_d;
      data1_q  <= data1_d;
      data2_q  <= data2_d;
      funct3_q <= funct3_d;
      funct7_q <= funct7_d;
      opcode_q <= opcode_d;
      rd_q     <= rd_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
    end
  end

  assign bus.valid_ex     = valid_q;
  assign bus.PC_EX        = pc_q;
  assign bus.IMM_EX       = imm_q;
  assign bus.REG_DATA1_EX = data1_q;
  assign bus.REG_DATA2_EX = data2_q;
  assign bus.FUNCT3_EX    = funct3_q;
  assign bus.FUNCT7_EX    = funct7_q;
  assign bus.OPCODE_EX    = opcode_q;
  assign bus.RD_EX        = rd_q;
  assign bus.RS1_EX       = rs1_q;
  assign bus.RS2_EX       = rs2_q;

endmodule
